// File: rtl/lsu_ctrl_if.sv
// Data-memory port of the load/store unit: request channel (addr/we/be/wdata) and
// response channel (rsp_valid/rdata). The LSU is the master, the memory the slave.
interface lsu_ctrl_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) ();

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [XLEN/8-1:0]   mem_be;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_rsp_valid;
    logic [XLEN-1:0]     mem_rdata;

    modport master (
        output mem_req_valid,
        output mem_addr,
        output mem_we,
        output mem_be,
        output mem_wdata,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        input  mem_we,
        input  mem_be,
        input  mem_wdata,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_ctrl.sv
// RISC-V load/store unit: address generation, alignment/funct3 checks, one memory transaction
// at a time. Define LSU_TIMEOUT_EN to add the bus watchdog and stale-response filter.
module lsu_ctrl #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [6:0]        req_opcode_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [11:0]       req_imm_i,
    input  logic [XLEN-1:0]   req_base_i,
    input  logic [XLEN-1:0]   req_wdata_i,

    lsu_ctrl_if.master        mem_if,

    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_data_o,
    output logic [1:0]        rsp_err_o
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned LW = $clog2(NB);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrAlign   = 2'b01;
    localparam logic [1:0] ErrIllegal = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [NB-1:0]       be_q, be_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [2:0]          f3_q, f3_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [1:0]          err_q, err_d;

    logic                tmo_hit;
    logic                rsp_discard;

    // Request decode
    logic [XLEN-1:0]     eff_addr;
    logic                is_load;
    logic                is_store;
    logic                legal;
    logic [LW-1:0]       off_mask;
    logic                misaligned;
    logic [NB-1:0]       size_be;
    logic [NB-1:0]       be_req;
    logic [XLEN-1:0]     wdata_rep;
    int unsigned         size_bytes;

    always_comb begin
        eff_addr = req_base_i + {{(XLEN-12){req_imm_i[11]}}, req_imm_i};
        is_load  = (req_opcode_i == OpLoad);
        is_store = (req_opcode_i == OpStore);

        legal = 1'b0;
        if (is_load) begin
            case (req_funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = (XLEN == 64);
                default:                                legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (req_funct3_i)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b011:                 legal = (XLEN == 64);
                default:                legal = 1'b0;
            endcase
        end

        off_mask   = LW'((32'd1 << req_funct3_i[1:0]) - 32'd1);
        misaligned = |(eff_addr[LW-1:0] & off_mask);

        size_bytes = 32'd1 << req_funct3_i[1:0];
        size_be    = NB'((32'd1 << size_bytes) - 32'd1);
        be_req     = size_be << eff_addr[LW-1:0];

        // An aligned access lands in lanes that are a multiple of its size, so repeating
        // the low bytes across the word puts the data wherever be selects.
        wdata_rep = '0;
        for (int i = 0; i < int'(NB); i++) begin
            wdata_rep[i*8 +: 8] = req_wdata_i[(i % int'(size_bytes))*8 +: 8];
        end
    end

    // Load extraction: shift the addressed lane down, then sign/zero-extend via shifts
    logic [XLEN-1:0]     rd_shifted;
    logic [XLEN-1:0]     rd_tmp;
    logic [XLEN-1:0]     load_ext;
    int unsigned         ext_sh;

    always_comb begin
        rd_shifted = mem_if.mem_rdata >> {lane_q, 3'b000};
        ext_sh     = XLEN - (32'd8 << f3_q[1:0]);
        rd_tmp     = rd_shifted << ext_sh;
        if (f3_q[2]) begin
            load_ext = rd_tmp >> ext_sh;
        end else begin
            load_ext = $unsigned($signed(rd_tmp) >>> ext_sh);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        data_d  = data_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    f3_d   = req_funct3_i;
                    lane_d = eff_addr[LW-1:0];
                    data_d = '0;
                    if (!legal) begin
                        err_d   = ErrIllegal;
                        state_d = StResp;
                    end else if (misaligned) begin
                        err_d   = ErrAlign;
                        state_d = StResp;
                    end else begin
                        err_d   = ErrOk;
                        addr_d  = {eff_addr[ADDR_W-1:LW], {LW{1'b0}}};
                        we_d    = is_store;
                        be_d    = be_req;
                        wdata_d = is_store ? wdata_rep : '0;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_if.mem_req_ready) begin
                    state_d = StWait;
                end else if (tmo_hit) begin
                    err_d   = ErrTimeout;
                    state_d = StResp;
                end
            end
            StWait: begin
                if (mem_if.mem_rsp_valid && !rsp_discard) begin
                    data_d  = we_q ? '0 : load_ext;
                    state_d = StResp;
                end else if (tmo_hit) begin
                    err_d   = ErrTimeout;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stale_q, stale_d;

    assign tmo_hit     = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign rsp_discard = stale_q;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StReq || state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end

        // An abort in WAIT leaves a response owed by memory; swallow it when it arrives
        stale_d = stale_q;
        if (stale_q && mem_if.mem_rsp_valid) begin
            stale_d = 1'b0;
        end
        if (state_q == StWait && state_d == StResp && err_d == ErrTimeout) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign rsp_discard = 1'b0;
`endif

    assign req_ready_o          = (state_q == StIdle);
    assign mem_if.mem_req_valid = (state_q == StReq);
    assign mem_if.mem_addr      = addr_q;
    assign mem_if.mem_we        = we_q;
    assign mem_if.mem_be        = be_q;
    assign mem_if.mem_wdata     = wdata_q;
    assign rsp_valid_o          = (state_q == StResp);
    assign rsp_data_o           = data_q;
    assign rsp_err_o            = err_q;

    a_params: assert property (@(posedge clk_i)
        (XLEN == 32 || XLEN == 64) && (ADDR_W <= XLEN) && (TIMEOUT_CYCLES > 0));

endmodule
